// File: rtl/median_pkg.sv
// Shared types and constants for the 3x3 median window datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package median_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN_SIZE = 9;

    // Window tap positions: row-major, top-left first.
    localparam int W_TL = 0;
    localparam int W_TC = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_MC = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BC = 7;
    localparam int W_BR = 8;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/line_buffer.sv
// One-line pixel store: combinational read and registered write at the same address.
// Latency: read data is available in the same cycle; a write lands on the next rising edge.
// Backpressure: none; en_i gates the write.
// Ports: clk_i clock, en_i write enable, addr_i column, wr_dat_i write data, rd_dat_o old data.
module line_buffer #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = 6
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    output logic [WIDTH-1:0] rd_dat_o
);

    // Contents are not reset: stale lines are masked by the window valid logic.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read-before-write: the read returns the pixel from one line earlier.
    assign rd_dat_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[addr_i] <= wr_dat_i;
        end
    end

endmodule

// File: rtl/median_window_gen.sv
// Builds a registered 3x3 pixel window from a raster stream for a downstream median sorter.
// Latency: 1 clock from the accepted pixel to its window; W8 equals that pixel.
// Backpressure: none; every accepted pixel is consumed and every window is taken.
// Ports: clk, rst (async active-low), in_pix/in_valid/in_sof input stream,
//        W0..W8 window (top row first), out_valid interior window, frame_done last-pixel pulse.
module median_window_gen
    import median_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic [PIX_W-1:0] W0,
    output logic [PIX_W-1:0] W1,
    output logic [PIX_W-1:0] W2,
    output logic [PIX_W-1:0] W3,
    output logic [PIX_W-1:0] W4,
    output logic [PIX_W-1:0] W5,
    output logic [PIX_W-1:0] W6,
    output logic [PIX_W-1:0] W7,
    output logic [PIX_W-1:0] W8,
    output logic             out_valid,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;
    pix_t          win_q [WIN_SIZE];
    pix_t          win_d [WIN_SIZE];
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;
    pix_t          lb1_rd, lb2_rd;

    // Start-of-frame forces this pixel to (0,0) whatever the counters say.
    assign col_cur = in_sof ? '0 : col_q;
    assign row_cur = in_sof ? '0 : row_q;

    // lb1 holds the previous line, lb2 the one before; lb1's old pixel cascades into lb2.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
        .clk_i    (clk),
        .en_i     (in_valid),
        .addr_i   (col_cur),
        .wr_dat_i (in_pix),
        .rd_dat_o (lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb2 (
        .clk_i    (clk),
        .en_i     (in_valid),
        .addr_i   (col_cur),
        .wr_dat_i (lb1_rd),
        .rd_dat_o (lb2_rd)
    );

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        out_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (in_valid) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
            end else begin
                col_d = col_cur + CW'(1);
                row_d = row_cur;
            end
            // Columns move left; the new right column is the vertical slice at col_cur.
            win_d[W_TL] = win_q[W_TC];
            win_d[W_TC] = win_q[W_TR];
            win_d[W_TR] = lb2_rd;
            win_d[W_ML] = win_q[W_MC];
            win_d[W_MC] = win_q[W_MR];
            win_d[W_MR] = lb1_rd;
            win_d[W_BL] = win_q[W_BC];
            win_d[W_BC] = win_q[W_BR];
            win_d[W_BR] = in_pix;
            // Windows touching the top two rows or left two columns hold border data.
            out_valid_d  = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
            frame_done_d = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < WIN_SIZE; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
            win_q        <= win_d;
        end
    end

    assign W0         = win_q[W_TL];
    assign W1         = win_q[W_TC];
    assign W2         = win_q[W_TR];
    assign W3         = win_q[W_ML];
    assign W4         = win_q[W_MC];
    assign W5         = win_q[W_MR];
    assign W6         = win_q[W_BL];
    assign W7         = win_q[W_BC];
    assign W8         = win_q[W_BR];
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/median_window_gen.md
MEDIAN_WINDOW_GEN -- requirements
Module: median_window_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 64, pixels per line (range 3..1024).
REQ-002 SHALL have parameter IMG_H, default 64, lines per frame (range 3..1024).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_pix, input, 8, unsigned raster-scan pixel.
REQ-006 SHALL have port in_valid, input, 1, in_pix is accepted this cycle.
REQ-007 SHALL have port in_sof, input, 1, start of frame; qualified by in_valid.
REQ-008 SHALL have ports W0..W8, output, 8 each, registered 3x3 window: W0..W2 = top row, W3..W5 = middle row, W6..W8 = bottom row, left to right.
REQ-009 SHALL have port out_valid, output, 1, W0..W8 hold a complete interior window.
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-011 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), both advancing only on accepted pixels.
REQ-012 On an accepted pixel, col SHALL increment, wrapping from IMG_W-1 to 0 with row incrementing; at row IMG_H-1 and col IMG_W-1, both SHALL return to 0.
REQ-013 An accepted pixel with in_sof=1 SHALL be treated as position (0,0), regardless of counter state; counters continue from there.
REQ-014 SHALL store the two previous lines in two line buffers of depth IMG_W, read-before-write at address col; the pixel read from buffer 1 is written to buffer 2, and in_pix is written to buffer 1.
REQ-015 SHALL keep a 3x3 shift register; on each accepted pixel, columns shift left and the new right column = {line buffer 2 out, line buffer 1 out, in_pix}.
REQ-016 out_valid SHALL be 1 in the cycle after a pixel is accepted at row>=2 and col>=2, and 0 otherwise, including after any cycle with in_valid=0.
REQ-017 Latency SHALL be one clock from the accepted pixel to its window on W0..W8; W8 equals that pixel.
REQ-018 W0..W8 SHALL hold their value when in_valid=0.
REQ-019 frame_done SHALL pulse high the cycle after pixel (IMG_H-1, IMG_W-1) is accepted, coincident with the final out_valid.
REQ-020 Windows per frame SHALL number exactly (IMG_W-2)*(IMG_H-2); border pixels produce no window.
REQ-021 No backpressure SHALL exist; the downstream sorting network is combinational and consumes every window.

Reset
REQ-022 With rst=0, col, row, out_valid, frame_done and W0..W8 SHALL clear to 0 immediately, asynchronously.
REQ-023 Line buffer contents SHALL NOT be cleared; stale data is never emitted because of REQ-016.
REQ-024 Reset mid-frame SHALL restart at (0,0) on the first accepted pixel after rst is released.

Structure
REQ-025 Shared package median_pkg SHALL hold PIX_W=8, WIN_SIZE=9 and the window index constants.
REQ-026 Sub-module line_buffer (depth IMG_W, width PIX_W, one read-before-write port, enable) SHALL be instantiated twice.

Verification (IMG_W=4, IMG_H=4, pixel = row*16+col)
REQ-027 Stream 16 pixels in consecutive cycles, starting with in_sof -> first out_valid follows pixel 0x22 with W0..W8 = 00,01,02,10,11,12,20,21,22; exactly 4 windows are produced.
REQ-028 Same stream with in_valid low for 3 cycles after every pixel -> identical window sequence; out_valid is never high two cycles in a row; W0..W8 stay stable in the gaps.
REQ-029 Last pixel 0x33 accepted -> frame_done and out_valid are high together for one cycle with W0 = 0x11 and W8 = 0x33; a second back-to-back frame produces 4 more windows.
REQ-030 in_sof asserted on the 7th pixel of a frame -> that pixel is treated as (0,0); no window until 10 more pixels are accepted.
REQ-031 rst pulled low after the 10th pixel -> outputs are 0 immediately; after release, a fresh 16-pixel frame yields exactly 4 correct windows.
